riscv_hazard_unit: RTL
======================

Name: riscv_hazard_unit

Overview:
- Pipeline control block next to the forwarding unit in the 5-stage RV32I core.
- Detects the hazards that forwarding cannot cover and drives the stall, bubble and freeze enables of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers:
  - load-use hazards;
  - ID-resolved branch/jalr operand hazards;
  - data-memory wait.
- Applies the IF/ID flush on a taken redirect, keeps registered hazard status, saturating performance counters and a memory-wait watchdog.

Parameters:
- REG_ADDR_W, 5, register index width.
- CNT_W, 32, width of the stall and flush counters.
- TIMEOUT, 255, consecutive MEM_WAIT cycles before mem_timeout is raised (1..2^16-1).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- IF_ID_opcode  input  5  instr[6:2] of the instruction in ID.
- IF_ID_rs1_idx  input  REG_ADDR_W  rs1 of the instruction in ID.
- IF_ID_rs2_idx  input  REG_ADDR_W  rs2 of the instruction in ID.
- ID_EX_RegWr  input  1  EX-stage instruction writes rd.
- ID_EX_MemtoReg  input  1  EX-stage instruction is a load.
- ID_EX_rd_idx  input  REG_ADDR_W  EX-stage rd.
- EX_MEM_RegWr  input  1  MEM-stage instruction writes rd.
- EX_MEM_rd_idx  input  REG_ADDR_W  MEM-stage rd.
- dmem_req  input  1  MEM stage has an outstanding data access.
- dmem_ready  input  1  data memory completes the access this cycle.
- ID_redirect  input  1  branch/jal/jalr in ID is taken.
- PC_Wr  output  1  PC update enable.
- IF_ID_Wr  output  1  IF/ID load enable.
- IF_ID_flush  output  1  IF/ID loads a NOP.
- ID_EX_flush  output  1  ID/EX loads a bubble (all control zero).
- EX_MEM_Wr  output  1  EX/MEM load enable.
- MEM_WB_Wr  output  1  MEM/WB load enable.
- hazard_state  output  2  registered class of the previous cycle: 0 RUN, 1 LOAD_STALL, 2 BRANCH_STALL, 3 MEM_WAIT.
- stall_cnt  output  CNT_W  cycles with PC_Wr=0, saturating.
- flush_cnt  output  CNT_W  cycles with IF_ID_flush=1, saturating.
- mem_timeout  output  1  sticky watchdog flag.

Behaviour:
- Reset: the asynchronous rst_n=0 forces these values immediately:
  - hazard_state=0, stall_cnt=0, flush_cnt=0, wait counter=0, mem_timeout=0.
  - Combinational outputs settle to the RUN values: PC_Wr=IF_ID_Wr=EX_MEM_Wr=MEM_WB_Wr=1, flushes=0, as long as dmem_req=0 and ID_redirect=0.
- Operand usage in ID:
  - uses_rs1 = opcode not in {01101 lui, 00101 auipc, 11011 jal}.
  - uses_rs2 = opcode in {01100 R-type, 01000 store, 11000 branch}.
  - Index 0 never matches.
- Load-use (LU): ID_EX_RegWr & ID_EX_MemtoReg & rd!=0 & rd matches a used rs.
- Branch operand hazard (BH), only when opcode is 11000 or 11001:
  - any ID_EX_RegWr match on a used rs; or
  - any EX_MEM_RegWr match on a used rs.
  - Reason: ID forwarding exists only from MEM/WB. A load feeding a branch therefore stalls 2 cycles, and an ALU result feeding a branch stalls 1–2 cycles, purely by per-cycle re-evaluation.
- Class this cycle, in priority order:
  1. MEM_WAIT if dmem_req & ~dmem_ready. Freeze everything: all five enables 0, both flushes 0.
  2. LOAD_STALL if LU. PC_Wr=0, IF_ID_Wr=0, ID_EX_flush=1, EX_MEM_Wr=MEM_WB_Wr=1, IF_ID_flush=0.
  3. BRANCH_STALL if BH (LU has priority). Same outputs as LOAD_STALL.
  4. RUN otherwise. All enables 1; IF_ID_flush=ID_redirect; ID_EX_flush=0.
- ID_redirect is ignored in every non-RUN class; the redirect re-presents once its operands are valid.
- No flush occurs during MEM_WAIT. The branch is held in ID and flushes in the first RUN cycle.
- Control outputs are combinational and have zero latency. hazard_state is registered, one cycle behind.
- stall_cnt +1 on every edge where PC_Wr=0; flush_cnt +1 where IF_ID_flush=1. Both hold at all-ones.
- Watchdog: the wait counter increments in each MEM_WAIT cycle and clears in any other class.
  - When the counter reaches TIMEOUT, mem_timeout is set and remains 1 until reset.
  - Pipeline behaviour is unchanged.

Test Plan:
- Reset, then idle with ID=addi x1,x2,3 and no matches -> all enables 1, flushes 0, hazard_state 0, counters 0.
- ID_EX = lw x5 (RegWr=1, MemtoReg=1, rd=5); ID = add x6,x5,x7 -> one cycle of PC_Wr=0, IF_ID_Wr=0, ID_EX_flush=1. Next cycle hazard_state=1 and stall_cnt=1; with ID_EX now a bubble, RUN resumes.
- lw x3 in ID_EX, then beq x3,x0 in ID -> two stall cycles (LU, then BH via EX_MEM) and stall_cnt=2. If ID_redirect=1 in the next RUN cycle -> IF_ID_flush=1 and flush_cnt=1.
- ID_EX rd=0 with RegWr=1, and ID uses x0 -> no stall. An addi in ID with rs2 matching ID_EX rd (load) -> no stall.
- dmem_req=1, dmem_ready=0 for 3 cycles while ID_redirect=1 and LU is true -> all enables 0 and no flushes for 3 cycles, hazard_state=3, stall_cnt=3.
- TIMEOUT=4, dmem_ready held 0 -> mem_timeout rises after the 4th wait cycle and stays 1 after ready returns. Asserting rst_n=0 mid-wait clears every register asynchronously.

Source files
------------

// File: rtl/riscv_hazard_unit.sv
// Purpose: load-use / ID-branch / dmem-wait hazard control for the 5-stage RV32I pipeline.
// Latency: stall, bubble, freeze and flush enables are combinational (0 cycles); hazard_state and counters are registered (1 cycle).
// Backpressure: an outstanding dmem access freezes every pipeline register; data hazards stall PC and IF/ID and bubble ID/EX.
module riscv_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            IF_ID_opcode,
    input  logic [REG_ADDR_W-1:0] IF_ID_rs1_idx,
    input  logic [REG_ADDR_W-1:0] IF_ID_rs2_idx,
    input  logic                  ID_EX_RegWr,
    input  logic                  ID_EX_MemtoReg,
    input  logic [REG_ADDR_W-1:0] ID_EX_rd_idx,
    input  logic                  EX_MEM_RegWr,
    input  logic [REG_ADDR_W-1:0] EX_MEM_rd_idx,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    input  logic                  ID_redirect,
    output logic                  PC_Wr,
    output logic                  IF_ID_Wr,
    output logic                  IF_ID_flush,
    output logic                  ID_EX_flush,
    output logic                  EX_MEM_Wr,
    output logic                  MEM_WB_Wr,
    output logic [1:0]            hazard_state,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic                  mem_timeout
);

    typedef enum logic [1:0] {
        HZ_RUN          = 2'd0,
        HZ_LOAD_STALL   = 2'd1,
        HZ_BRANCH_STALL = 2'd2,
        HZ_MEM_WAIT     = 2'd3
    } hz_class_e;

    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_RTYPE  = 5'b01100;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    // Wait counter is wide enough for the largest allowed TIMEOUT and saturates there.
    localparam int                WAIT_W    = 16;
    localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);

    logic            uses_rs1, uses_rs2, is_id_branch;
    logic            rs1_ex_hit, rs2_ex_hit, rs1_mem_hit, rs2_mem_hit;
    logic            load_use, branch_hz, mem_wait;
    hz_class_e       hz_class;

    hz_class_e         hazard_state_q, hazard_state_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;

    // Decode which source registers the ID instruction reads and match them (x0 never matches).
    always_comb begin
        uses_rs1     = !(IF_ID_opcode == OP_LUI || IF_ID_opcode == OP_AUIPC ||
                         IF_ID_opcode == OP_JAL);
        uses_rs2     = (IF_ID_opcode == OP_RTYPE || IF_ID_opcode == OP_STORE ||
                        IF_ID_opcode == OP_BRANCH);
        is_id_branch = (IF_ID_opcode == OP_BRANCH || IF_ID_opcode == OP_JALR);

        rs1_ex_hit  = uses_rs1 && (IF_ID_rs1_idx != '0) && (IF_ID_rs1_idx == ID_EX_rd_idx);
        rs2_ex_hit  = uses_rs2 && (IF_ID_rs2_idx != '0) && (IF_ID_rs2_idx == ID_EX_rd_idx);
        rs1_mem_hit = uses_rs1 && (IF_ID_rs1_idx != '0) && (IF_ID_rs1_idx == EX_MEM_rd_idx);
        rs2_mem_hit = uses_rs2 && (IF_ID_rs2_idx != '0) && (IF_ID_rs2_idx == EX_MEM_rd_idx);

        load_use  = ID_EX_RegWr && ID_EX_MemtoReg && (rs1_ex_hit || rs2_ex_hit);
        // ID only forwards from MEM/WB, so any producer still in EX or MEM blocks a branch compare.
        branch_hz = is_id_branch &&
                    ((ID_EX_RegWr && (rs1_ex_hit || rs2_ex_hit)) ||
                     (EX_MEM_RegWr && (rs1_mem_hit || rs2_mem_hit)));
        mem_wait  = dmem_req && !dmem_ready;
    end

    // Classify the cycle by priority and drive the pipeline enables; redirects only act in RUN.
    always_comb begin
        hz_class    = HZ_RUN;
        PC_Wr       = 1'b1;
        IF_ID_Wr    = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        EX_MEM_Wr   = 1'b1;
        MEM_WB_Wr   = 1'b1;
        if (mem_wait) begin
            hz_class  = HZ_MEM_WAIT;
            PC_Wr     = 1'b0;
            IF_ID_Wr  = 1'b0;
            EX_MEM_Wr = 1'b0;
            MEM_WB_Wr = 1'b0;
        end else if (load_use || branch_hz) begin
            hz_class    = load_use ? HZ_LOAD_STALL : HZ_BRANCH_STALL;
            PC_Wr       = 1'b0;
            IF_ID_Wr    = 1'b0;
            ID_EX_flush = 1'b1;
        end else begin
            IF_ID_flush = ID_redirect;
        end
    end

    // Next-state for status, saturating counters and the memory-wait watchdog.
    always_comb begin
        hazard_state_d = hz_class;
        stall_cnt_d    = stall_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        wait_cnt_d     = '0;
        mem_timeout_d  = mem_timeout_q;
        if (!PC_Wr && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (IF_ID_flush && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (mem_wait) begin
            wait_cnt_d = (wait_cnt_q >= TIMEOUT_C) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
            if (wait_cnt_d == TIMEOUT_C) begin
                mem_timeout_d = 1'b1;
            end
        end
    end

    // Status and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hazard_state_q <= HZ_RUN;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
            wait_cnt_q     <= '0;
            mem_timeout_q  <= 1'b0;
        end else begin
            hazard_state_q <= hazard_state_d;
            stall_cnt_q    <= stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
        end
    end

    assign hazard_state = hazard_state_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;
    assign mem_timeout  = mem_timeout_q;

endmodule
